// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS encoding constants for the IF/ID stage.
//   - Bit offsets and widths of the op, rs, rt, rd, funct and imm16 fields.
//   - NOP encoding driven on the decode side whenever nothing valid is held.
//   - State encoding of the optional two-entry skid buffer.
package mips_pkg;

    localparam int unsigned OpLsb    = 26;
    localparam int unsigned OpW      = 6;
    localparam int unsigned RsLsb    = 21;
    localparam int unsigned RsW      = 5;
    localparam int unsigned RtLsb    = 16;
    localparam int unsigned RtW      = 5;
    localparam int unsigned RdLsb    = 11;
    localparam int unsigned RdW      = 5;
    localparam int unsigned FunctLsb = 0;
    localparam int unsigned FunctW   = 6;
    localparam int unsigned Imm16Lsb = 0;
    localparam int unsigned Imm16W   = 16;

    // sll $0,$0,0
    localparam logic [31:0] NopInstr = 32'h0000_0000;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/if_id_skid.sv
// if_id_skid: two-entry skid buffer between fetch and decode.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   flush_i            : drop both entries and the same-cycle input transfer
//   in_valid_i/in_ready_o/in_pc_i/in_instr_i     : upstream handshake; in_ready_o is a register
//   out_valid_o/out_ready_i/out_pc_o/out_instr_o : downstream handshake, head entry
// Head holds the oldest entry; the skid entry only fills when the head is stalled.
module if_id_skid
    import mips_pkg::*;
#(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [PC_W-1:0]    in_pc_i,
    input  logic [INSTR_W-1:0] in_instr_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [PC_W-1:0]    out_pc_o,
    output logic [INSTR_W-1:0] out_instr_o
);

    skid_state_e        state_q, state_d;
    logic               ready_q;
    logic [PC_W-1:0]    head_pc_q, head_pc_d, skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0] head_instr_q, head_instr_d, skid_instr_q, skid_instr_d;
    logic               accept, consume;

    assign in_ready_o  = ready_q;
    assign out_valid_o = (state_q != StEmpty);
    assign out_pc_o    = head_pc_q;
    assign out_instr_o = head_instr_q;

    assign accept  = in_valid_i && ready_q;
    assign consume = out_valid_o && out_ready_i;

    always_comb begin
        state_d      = state_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if (flush_i) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        head_pc_d    = in_pc_i;
                        head_instr_d = in_instr_i;
                        state_d      = StOne;
                    end
                end
                StOne: begin
                    if (accept && consume) begin
                        head_pc_d    = in_pc_i;
                        head_instr_d = in_instr_i;
                    end else if (accept) begin
                        skid_pc_d    = in_pc_i;
                        skid_instr_d = in_instr_i;
                        state_d      = StFull;
                    end else if (consume) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    // ready_q is low here, so no accept can coincide
                    if (consume) begin
                        head_pc_d    = skid_pc_q;
                        head_instr_d = skid_instr_q;
                        state_d      = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StEmpty;
            ready_q      <= 1'b1;
            head_pc_q    <= '0;
            head_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            // Registered ready: derived from next state, so no path from out_ready_i
            ready_q      <= (state_d != StFull);
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with valid/ready handshakes and flush.
//   clk_i, rst_i                          : clock, synchronous active-high reset
//   f_valid_i/f_ready_o/f_pc_i/f_instr_i  : fetch-side handshake
//   flush_i                               : discard held and incoming instructions
//   d_valid_o/d_ready_i/d_pc_o/d_instr_o  : decode-side handshake
//   d_rs_o, d_rt_o, d_rd_o, d_op_o, d_funct_o, d_imm16_o : fields sliced from d_instr_o
// Build option: define IF_ID_SKID_EN for a two-entry skid buffer with registered
// f_ready_o; otherwise a single register with f_ready_o = !d_valid_o || d_ready_i.
// d_instr_o reads as NOP and d_pc_o as zero whenever d_valid_o is low.
module if_id_stage
    import mips_pkg::*;
#(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               f_valid_i,
    output logic               f_ready_o,
    input  logic [PC_W-1:0]    f_pc_i,
    input  logic [INSTR_W-1:0] f_instr_i,
    input  logic               flush_i,
    output logic               d_valid_o,
    input  logic               d_ready_i,
    output logic [PC_W-1:0]    d_pc_o,
    output logic [INSTR_W-1:0] d_instr_o,
    output logic [4:0]         d_rs_o,
    output logic [4:0]         d_rt_o,
    output logic [4:0]         d_rd_o,
    output logic [5:0]         d_op_o,
    output logic [5:0]         d_funct_o,
    output logic [15:0]        d_imm16_o
);

    logic               hold_valid;
    logic [PC_W-1:0]    hold_pc;
    logic [INSTR_W-1:0] hold_instr;

`ifdef IF_ID_SKID_EN

    logic skid_ready;

    if_id_skid #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (f_valid_i),
        .in_ready_o  (skid_ready),
        .in_pc_i     (f_pc_i),
        .in_instr_i  (f_instr_i),
        .out_valid_o (hold_valid),
        .out_ready_i (d_ready_i),
        .out_pc_o    (hold_pc),
        .out_instr_o (hold_instr)
    );

    // Reset cycles never advertise space
    assign f_ready_o = skid_ready && !rst_i;

`else

    logic               valid_q, valid_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               accept, consume;

    assign f_ready_o = !rst_i && (!valid_q || d_ready_i);
    assign accept    = f_valid_i && f_ready_o;
    assign consume   = valid_q && d_ready_i;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            pc_d    = f_pc_i;
            instr_d = f_instr_i;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign hold_valid = valid_q;
    assign hold_pc    = pc_q;
    assign hold_instr = instr_q;

`endif

    assign d_valid_o = hold_valid;
    assign d_pc_o    = hold_valid ? hold_pc : '0;
    assign d_instr_o = hold_valid ? hold_instr : INSTR_W'(NopInstr);

    assign d_op_o    = d_instr_o[OpLsb    +: OpW];
    assign d_rs_o    = d_instr_o[RsLsb    +: RsW];
    assign d_rt_o    = d_instr_o[RtLsb    +: RtW];
    assign d_rd_o    = d_instr_o[RdLsb    +: RdW];
    assign d_funct_o = d_instr_o[FunctLsb +: FunctW];
    assign d_imm16_o = d_instr_o[Imm16Lsb +: Imm16W];

endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed scenarios plus a randomized run against a queue model.
module tb_if_id_stage;

`ifdef IF_ID_SKID_EN
    localparam bit Skid = 1'b1;
`else
    localparam bit Skid = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, f_valid, flush, d_ready;
    logic        f_ready, d_valid;
    logic [31:0] f_pc, f_instr, d_pc, d_instr;
    logic [4:0]  d_rs, d_rt, d_rd;
    logic [5:0]  d_op, d_funct;
    logic [15:0] d_imm16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_id_stage #(
        .PC_W    (32),
        .INSTR_W (32)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .f_valid_i (f_valid),
        .f_ready_o (f_ready),
        .f_pc_i    (f_pc),
        .f_instr_i (f_instr),
        .flush_i   (flush),
        .d_valid_o (d_valid),
        .d_ready_i (d_ready),
        .d_pc_o    (d_pc),
        .d_instr_o (d_instr),
        .d_rs_o    (d_rs),
        .d_rt_o    (d_rt),
        .d_rd_o    (d_rd),
        .d_op_o    (d_op),
        .d_funct_o (d_funct),
        .d_imm16_o (d_imm16)
    );

    // Advance past the next rising edge; inputs change 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; f_valid = 1'b1; f_pc = 32'h100; f_instr = 32'hdead_beef;
        flush = 1'b0; d_ready = 1'b1;
        #2;
        checks++; if (f_ready !== 1'b0) begin errors++;
            $display("FAIL reset_ready_in_rst: got %b want 0", f_ready); end
        tick(); #2;
        checks++; if (d_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %b want 0", d_valid); end
        checks++; if (d_instr !== 32'h0) begin errors++;
            $display("FAIL reset_instr: got %h want 00000000", d_instr); end
        checks++; if (d_pc !== 32'h0) begin errors++;
            $display("FAIL reset_pc: got %h want 00000000", d_pc); end
        tick();
        rst = 1'b0; f_valid = 1'b0;
        #2;
        checks++; if (f_ready !== 1'b1) begin errors++;
            $display("FAIL reset_ready_after: got %b want 1", f_ready); end
        checks++; if (d_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid_after: got %b want 0", d_valid); end
    endtask

    task automatic test_stream();
        f_valid = 1'b1; f_pc = 32'h0; f_instr = 32'h2008_0005; d_ready = 1'b1;
        tick();
        f_pc = 32'h4; f_instr = 32'h2009_0006;
        #2;
        checks++; if ({d_valid, d_pc} !== {1'b1, 32'h0}) begin errors++;
            $display("FAIL stream_c1: got v=%b pc=%h want v=1 pc=00000000", d_valid, d_pc); end
        checks++; if ({d_imm16, d_op, d_rs, d_rt} !== {16'h0005, 6'd8, 5'd0, 5'd8}) begin
            errors++;
            $display("FAIL stream_fields: got imm=%h op=%0d rs=%0d rt=%0d want imm=0005 op=8 rs=0 rt=8",
                     d_imm16, d_op, d_rs, d_rt); end
        tick();
        f_pc = 32'h8; f_instr = 32'h200a_0007;
        #2;
        checks++; if ({d_valid, d_pc, d_instr} !== {1'b1, 32'h4, 32'h2009_0006}) begin errors++;
            $display("FAIL stream_c2: got v=%b pc=%h want v=1 pc=00000004", d_valid, d_pc); end
        tick();
        f_valid = 1'b0;
        #2;
        checks++; if ({d_valid, d_pc} !== {1'b1, 32'h8}) begin errors++;
            $display("FAIL stream_c3: got v=%b pc=%h want v=1 pc=00000008", d_valid, d_pc); end
        tick(); #2;
        checks++; if ({d_valid, d_instr, d_imm16} !== {1'b0, 32'h0, 16'h0}) begin errors++;
            $display("FAIL stream_drain: got v=%b instr=%h imm=%h want 0/0/0",
                     d_valid, d_instr, d_imm16); end
    endtask

    task automatic test_stall();
        logic [31:0] pc;
        int          accepts;
        logic        rdy;
        pc = 32'h10; accepts = 0;
        f_valid = 1'b1; d_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            f_pc = pc; f_instr = 32'h2400_0000 | pc;
            #2;
            rdy = f_ready;
            checks++; if (rdy !== (i < (Skid ? 2 : 1))) begin errors++;
                $display("FAIL stall_ready_c%0d: got %b want %b", i, rdy, i < (Skid ? 2 : 1)); end
            if (i > 0) begin
                checks++; if ({d_valid, d_pc} !== {1'b1, 32'h10}) begin errors++;
                    $display("FAIL stall_hold_c%0d: got v=%b pc=%h want v=1 pc=00000010",
                             i, d_valid, d_pc); end
            end
            tick();
            if (rdy) begin accepts++; pc += 32'h4; end
        end
        checks++; if (accepts != (Skid ? 2 : 1)) begin errors++;
            $display("FAIL stall_accepts: got %0d want %0d", accepts, Skid ? 2 : 1); end
        f_pc = pc; f_instr = 32'h2400_0000 | pc; d_ready = 1'b1;
        #2;
        checks++; if ({d_valid, d_pc} !== {1'b1, 32'h10}) begin errors++;
            $display("FAIL stall_release0: got v=%b pc=%h want v=1 pc=00000010", d_valid, d_pc); end
        tick();
        f_valid = 1'b0;
        #2;
        checks++; if ({d_valid, d_pc, d_instr} !== {1'b1, 32'h14, 32'h2400_0014}) begin errors++;
            $display("FAIL stall_release1: got v=%b pc=%h instr=%h want v=1 pc=00000014 instr=24000014",
                     d_valid, d_pc, d_instr); end
        tick(); #2;
        checks++; if (d_valid !== 1'b0) begin errors++;
            $display("FAIL stall_drain: got %b want 0", d_valid); end
    endtask

    // Loads one (single-register) or two (skid) entries with decode stalled.
    task automatic fill(input logic [31:0] base);
        logic [31:0] pc;
        logic        rdy;
        pc = base; f_valid = 1'b1; d_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            f_pc = pc; f_instr = 32'h2400_0000 | pc;
            #2;
            rdy = f_ready;
            tick();
            if (rdy) pc += 32'h4;
        end
    endtask

    task automatic test_flush_full();
        fill(32'h30);
        flush = 1'b1; f_valid = 1'b1; f_pc = 32'h20; f_instr = 32'h2000_0020; d_ready = 1'b1;
        tick();
        flush = 1'b0; f_valid = 1'b0;
        #2;
        checks++; if ({d_valid, f_ready, d_instr} !== {1'b0, 1'b1, 32'h0}) begin errors++;
            $display("FAIL flush_full_next: got v=%b rdy=%b instr=%h want v=0 rdy=1 instr=0",
                     d_valid, f_ready, d_instr); end
        for (int i = 0; i < 3; i++) begin
            tick(); #2;
            checks++; if (d_valid !== 1'b0 || d_pc === 32'h20) begin errors++;
                $display("FAIL flush_full_leak_c%0d: got v=%b pc=%h want v=0", i, d_valid, d_pc); end
        end
        // Flush while the stage can accept: the offered word must still be dropped
        f_valid = 1'b1; f_pc = 32'h60; f_instr = 32'h2000_0060; d_ready = 1'b0;
        tick();
        flush = 1'b1; f_pc = 32'h24; f_instr = 32'h2000_0024; d_ready = 1'b1;
        #2;
        checks++; if (f_ready !== 1'b1) begin errors++;
            $display("FAIL flush_accept_ready: got %b want 1", f_ready); end
        tick();
        flush = 1'b0; f_valid = 1'b0;
        #2;
        checks++; if ({d_valid, d_instr} !== {1'b0, 32'h0}) begin errors++;
            $display("FAIL flush_accept_drop: got v=%b pc=%h want v=0", d_valid, d_pc); end
    endtask

    task automatic test_reset_stall();
        fill(32'h40);
        rst = 1'b1; f_valid = 1'b1; f_pc = 32'h48; d_ready = 1'b0;
        #2;
        checks++; if (f_ready !== 1'b0) begin errors++;
            $display("FAIL rst_stall_ready0: got %b want 0", f_ready); end
        tick(); #2;
        checks++; if ({d_valid, f_ready, d_instr} !== {1'b0, 1'b0, 32'h0}) begin errors++;
            $display("FAIL rst_stall_next: got v=%b rdy=%b instr=%h want 0/0/0",
                     d_valid, f_ready, d_instr); end
        tick();
        rst = 1'b0; f_pc = 32'h50; f_instr = 32'h2000_0050; d_ready = 1'b1;
        #2;
        checks++; if ({f_ready, d_valid} !== {1'b1, 1'b0}) begin errors++;
            $display("FAIL rst_stall_release: got rdy=%b v=%b want rdy=1 v=0", f_ready, d_valid); end
        tick();
        f_valid = 1'b0;
        #2;
        checks++; if ({d_valid, d_pc} !== {1'b1, 32'h50}) begin errors++;
            $display("FAIL rst_stall_first: got v=%b pc=%h want v=1 pc=00000050", d_valid, d_pc); end
        tick();
    endtask

    task automatic test_random();
        logic [63:0] q[$];
        logic        exp_ready, exp_valid, prev_stall;
        logic [31:0] prev_pc, prev_instr, hi;
        logic [63:0] exp_fields, got_fields;
        rst = 1'b1; flush = 1'b0; f_valid = 1'b0; d_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        prev_stall = 1'b0; prev_pc = '0; prev_instr = '0;
        for (int n = 0; n < 10000; n++) begin
            rst     = ($urandom_range(999) < 3);
            flush   = ($urandom_range(99) < 3);
            f_valid = ($urandom_range(99) < 70);
            d_ready = ($urandom_range(99) < 65);
            f_pc    = $urandom;
            f_instr = $urandom;
            #2;
            exp_valid = (q.size() != 0);
            if (rst)       exp_ready = 1'b0;
            else if (Skid) exp_ready = (q.size() < 2);
            else           exp_ready = !exp_valid || d_ready;
            checks++; if (f_ready !== exp_ready) begin errors++;
                $display("FAIL rand_ready@%0d: got %b want %b", n, f_ready, exp_ready); end
            checks++; if (d_valid !== exp_valid) begin errors++;
                $display("FAIL rand_valid@%0d: got %b want %b", n, d_valid, exp_valid); end
            hi = exp_valid ? q[0][31:0] : 32'h0;
            exp_fields = {exp_valid ? q[0][63:32] : 32'h0, hi};
            got_fields = {d_pc, d_instr};
            checks++; if (got_fields !== exp_fields) begin errors++;
                $display("FAIL rand_data@%0d: got pc=%h instr=%h want pc=%h instr=%h",
                         n, d_pc, d_instr, exp_fields[63:32], exp_fields[31:0]); end
            checks++;
            if ({d_op, d_rs, d_rt, d_rd, d_funct, d_imm16} !==
                {6'(hi >> 26), 5'(hi >> 21), 5'(hi >> 16), 5'(hi >> 11), 6'(hi), 16'(hi)}) begin
                errors++;
                $display("FAIL rand_fields@%0d: got op=%h rs=%h rt=%h rd=%h fn=%h imm=%h for instr %h",
                         n, d_op, d_rs, d_rt, d_rd, d_funct, d_imm16, hi); end
            if (prev_stall) begin
                checks++; if (d_pc !== prev_pc || d_instr !== prev_instr) begin errors++;
                    $display("FAIL rand_stable@%0d: got pc=%h instr=%h want pc=%h instr=%h",
                             n, d_pc, d_instr, prev_pc, prev_instr); end
            end
            prev_stall = exp_valid && !d_ready && !rst && !flush;
            prev_pc = d_pc; prev_instr = d_instr;
            tick();
            if (rst || flush) begin
                q.delete();
            end else begin
                if (exp_valid && d_ready) void'(q.pop_front());
                if (f_valid && exp_ready) q.push_back({f_pc, f_instr});
            end
        end
        rst = 1'b0; flush = 1'b0; f_valid = 1'b0; d_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush_full();
        test_reset_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter PC_W, default 32: program counter width.
REQ-002 SHALL have parameter INSTR_W, default 32: instruction width; fixed at 32 for MIPS decode.
REQ-003 SHALL have port clk_i, input, 1: the single clock, rising-edge active.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port f_valid_i, input, 1: fetch offers an instruction.
REQ-006 SHALL have port f_ready_o, output, 1: stage accepts an instruction.
REQ-007 SHALL have port f_pc_i, input, PC_W: PC of the offered instruction.
REQ-008 SHALL have port f_instr_i, input, INSTR_W: the offered instruction word.
REQ-009 SHALL have port flush_i, input, 1: discard all held and incoming instructions (taken branch or jump).
REQ-010 SHALL have port d_valid_o, output, 1: decode output is valid.
REQ-011 SHALL have port d_ready_i, input, 1: decode consumes the output.
REQ-012 SHALL have ports d_pc_o (PC_W) and d_instr_o (INSTR_W), outputs: the held PC and instruction.
REQ-013 SHALL have ports d_rs_o (5), d_rt_o (5), d_rd_o (5), d_op_o (6), d_funct_o (6) and d_imm16_o (16), outputs: instruction fields sliced from d_instr_o; d_imm16_o feeds the sign-extend unit.

Function
REQ-014 SHALL transfer upstream when f_valid_i && f_ready_o, and downstream when d_valid_o && d_ready_i.
REQ-015 SHALL present an accepted instruction on d_* exactly one cycle after acceptance when the stage was empty.
REQ-016 SHALL keep d_* outputs stable while d_valid_o && !d_ready_i.
REQ-017 SHALL preserve program order with no loss or duplication.
REQ-018 SHALL, when flush_i=1, clear all held entries at the next edge and ignore the same-cycle upstream transfer: flush wins over accept and consume.
REQ-019 SHALL, in the cycle after a flush, drive d_valid_o=0, and f_ready_o=1.
REQ-020 SHALL drive d_instr_o=32'h0000_0000 (NOP) whenever d_valid_o=0; the field outputs follow it.
REQ-021 SHALL accept and consume in the same cycle when holding exactly one entry with d_ready_i=1, sustaining one instruction per cycle.

Reset
REQ-022 SHALL, on rst_i=1 at a rising edge, set d_valid_o=0, d_pc_o=0 and d_instr_o=0, and empty all entries.
REQ-023 SHALL drive f_ready_o=0 in a reset cycle and 1 in the first cycle after reset.
REQ-024 SHALL let rst_i override flush_i and all handshake traffic, including mid-stall.

Configuration
REQ-025 SHALL, with IF_ID_SKID_EN defined, implement a 2-entry skid buffer with states EMPTY, ONE and FULL.
REQ-026 SHALL, with IF_ID_SKID_EN defined, drive f_ready_o from a register as f_ready_o = (state != FULL), with no combinational path from d_ready_i.
REQ-027 SHALL, with IF_ID_SKID_EN defined, make these transitions: EMPTY→ONE on accept; ONE→FULL on accept without consume; ONE→EMPTY on consume without accept; FULL→ONE on consume; all states→EMPTY on flush.
REQ-028 SHALL, without IF_ID_SKID_EN, implement a single register with f_ready_o = !d_valid_o || d_ready_i (combinational).

Structure
REQ-029 SHALL place the MIPS field offsets and widths (op, rs, rt, rd, funct, imm16), the NOP encoding and the state encoding in a shared package mips_pkg.
REQ-030 SHALL implement the skid buffer as a sub-module if_id_skid, instantiated only under IF_ID_SKID_EN; the field slicing stays in if_id_stage.

Verification
REQ-031 SHALL cover reset: assert rst_i for 2 cycles with f_valid_i=1 -> d_valid_o=0 and d_instr_o=0; f_ready_o=1 on the first cycle after release.
REQ-032 SHALL cover streaming: f_valid_i=1 with PCs 0x0,0x4,0x8 (instr 0x2008_0005 ...) and d_ready_i=1 -> d_pc_o=0x0,0x4,0x8 on cycles 1..3, and d_imm16_o=0x0005 on cycle 1.
REQ-033 SHALL cover stall: d_ready_i=0 for 3 cycles while offering PCs 0x10,0x14,0x18 -> d_pc_o holds 0x10; with IF_ID_SKID_EN f_ready_o drops after 2 accepts, without it after 1; on release the order is 0x10,0x14.
REQ-034 SHALL cover flush in FULL: flush_i=1 with f_valid_i=1 (PC 0x20) -> next cycle d_valid_o=0 and PC 0x20 is never output.
REQ-035 SHALL cover reset during stall: rst_i=1 while FULL -> next cycle d_valid_o=0 and f_ready_o=0; after release the first output is the first post-reset accept.
REQ-036 SHALL cover a random valid/ready scoreboard run of 10k cycles in both macro settings -> in-order, lossless, and d_* stable whenever stalled.
